uart_tx_sched: RTL and testbench



---
 rtl/uart_tx_sched.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Two-requester UART transmitter: round-robin arbitration between the CPU and
// debug byte streams, with packet locking and a lock timeout, feeding an 8N1 serializer.
module uart_tx_sched #(
  parameter int unsigned CLK_DIV      = 16,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_valid,
  input  logic [7:0] cpu_data,
  input  logic       cpu_last,
  output logic       cpu_ready,
  input  logic       dbg_valid,
  input  logic [7:0] dbg_data,
  input  logic       dbg_last,
  output logic       dbg_ready,
  output logic       tx,
  output logic       busy,
  output logic       cur_src,
  output logic       locked
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             rr_dbg;
  logic             lock_q;
  logic             owner;
  logic [TO_W-1:0]  to_cnt;
  logic             src_q;

  logic             sel_cpu;
  logic             sel_dbg;
  logic             accept;
  logic             acc_src;
  logic             acc_last;
  logic [7:0]       acc_data;
  logic             owner_valid;
  logic             bit_end;

  // Arbitration: a held lock restricts eligibility to its owner; otherwise
  // a tie goes to the source that did not win the previous grant.
  always_comb begin
    sel_cpu = 1'b0;
    sel_dbg = 1'b0;
    if (lock_q) begin
      sel_cpu = ~owner;
      sel_dbg = owner;
    end else if (cpu_valid && dbg_valid) begin
      sel_cpu = ~rr_dbg;
      sel_dbg = rr_dbg;
    end else begin
      sel_cpu = cpu_valid;
      sel_dbg = dbg_valid;
    end
  end

  always_comb begin
    accept      = cpu_ready | dbg_ready;
    acc_src     = dbg_ready;
    acc_data    = dbg_ready ? dbg_data : cpu_data;
    acc_last    = dbg_ready ? dbg_last : cpu_last;
    owner_valid = owner ? dbg_valid : cpu_valid;
    bit_end     = (state != IDLE) && (div_cnt == DIV_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && (bit_cnt == 3'd7)) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready = rst & (state == IDLE) & cpu_valid & sel_cpu;
    dbg_ready = rst & (state == IDLE) & dbg_valid & sel_dbg;
    busy      = (state != IDLE);
    tx        = 1'b1;
    unique case (state)
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      default: tx = 1'b1;
    endcase
  end

  // Divider restarts from zero at every bit boundary, so bit lengths never drift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (state == IDLE) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      if (accept) begin
        shreg <= acc_data;
      end
    end else if (bit_end) begin
      div_cnt <= '0;
      if (state == DATA) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Timeout counter only advances in IDLE while the owner is silent; it
  // saturates, and the lock drops the cycle after saturation is seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_dbg <= 1'b0;
      lock_q <= 1'b0;
      owner  <= 1'b0;
      to_cnt <= '0;
      src_q  <= 1'b0;
    end else if (accept) begin
      src_q  <= acc_src;
      rr_dbg <= ~acc_src;
      lock_q <= ~acc_last;
      if (!acc_last) begin
        owner <= acc_src;
      end
      to_cnt <= '0;
    end else begin
      if (lock_q && (to_cnt == TO_MAX)) begin
        lock_q <= 1'b0;
      end
      if (owner_valid) begin
        to_cnt <= '0;
      end else if ((state == IDLE) && lock_q && (to_cnt != TO_MAX)) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    cur_src = src_q;
    locked  = lock_q;
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: accepts are checked against a rule-level
// arbitration model, and every serial frame is decoded and compared cycle by cycle.
`timescale 1ns/1ps
module tb_uart_tx_sched;

  localparam int unsigned CLK_DIV      = 4;
  localparam int unsigned LOCK_TIMEOUT = 8;
  localparam int          FRAME        = 10 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_valid = 1'b0;
  logic [7:0] cpu_data = '0;
  logic       cpu_last = 1'b0;
  logic       dbg_valid = 1'b0;
  logic [7:0] dbg_data = '0;
  logic       dbg_last = 1'b0;
  logic       cpu_ready, dbg_ready, tx, busy, cur_src, locked;

  uart_tx_sched #(.CLK_DIV(CLK_DIV), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_last(cpu_last), .cpu_ready(cpu_ready),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_last(dbg_last), .dbg_ready(dbg_ready),
    .tx(tx), .busy(busy), .cur_src(cur_src), .locked(locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk_ok(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    chk_ok(act == exp, name, act, exp);
  endtask

  typedef struct {
    bit         src;
    logic [7:0] data;
    int         cyc;
  } frame_t;

  frame_t sb[$];

  // Reference arbitration state: lock flag/owner and who won the last grant.
  bit m_locked = 1'b0;
  bit m_owner  = 1'b0;
  bit m_last   = 1'b1;

  function automatic bit pick(input bit cv, input bit dv);
    if (m_locked) return m_owner;
    if (cv && dv) return !m_last;
    return dv;
  endfunction

  logic [8:0] cpu_q[$];
  logic [8:0] dbg_q[$];
  bit cpu_en = 1'b0, dbg_en = 1'b0, rnd_gaps = 1'b0, tight = 1'b0;
  int cpu_gap = 0, dbg_gap = 0;
  bit cpu_acc_s = 1'b0, dbg_acc_s = 1'b0;
  int acc_total = 0, acc_cyc = 0;
  bit acc_who = 1'b0;
  bit have_prev = 1'b0, chk_lock = 1'b0;
  int prev_acc = 0;

  frame_t cur;
  bit dec_active = 1'b0, dec_stray = 1'b0;
  int dec_cnt = 0, dec_bad = 0;

  always @(negedge clk) begin
    cpu_acc_s = 1'b0;
    dbg_acc_s = 1'b0;
    if (!rst) begin
      m_locked   = 1'b0;
      m_owner    = 1'b0;
      m_last     = 1'b1;
      sb.delete();
      dec_active = 1'b0;
      chk_lock   = 1'b0;
      have_prev  = 1'b0;
    end else begin
      if (chk_lock) begin
        chk("lock_after_accept", int'(locked), int'(m_locked));
        chk_lock = 1'b0;
      end
      if (cpu_ready === 1'b1 || dbg_ready === 1'b1) begin
        bit src;
        bit lst;
        frame_t f;
        chk("one_ready", int'(cpu_ready & dbg_ready), 0);
        src = (dbg_ready === 1'b1);
        chk("grant_src", int'(src), int'(pick(cpu_valid === 1'b1, dbg_valid === 1'b1)));
        chk("lock_at_accept", int'(locked), int'(m_locked));
        chk("idle_at_accept", int'(busy), 0);
        if (have_prev) begin
          if (tight) chk("pitch", cyc - prev_acc, FRAME + 1);
          else chk_ok(cyc - prev_acc >= FRAME + 1, "pitch_min", cyc - prev_acc, FRAME + 1);
        end
        have_prev = 1'b1;
        prev_acc  = cyc;
        f.src  = src;
        f.data = src ? dbg_data : cpu_data;
        f.cyc  = cyc;
        sb.push_back(f);
        lst    = src ? dbg_last : cpu_last;
        m_last = src;
        if (lst) m_locked = 1'b0;
        else begin
          m_locked = 1'b1;
          m_owner  = src;
        end
        chk_lock  = 1'b1;
        acc_total++;
        acc_cyc   = cyc;
        acc_who   = src;
        if (src) dbg_acc_s = 1'b1;
        else cpu_acc_s = 1'b1;
      end
      if (dec_active) begin
        int seg;
        logic ex;
        dec_cnt++;
        if (dec_cnt < FRAME) begin
          seg = dec_cnt / CLK_DIV;
          if (seg == 0) ex = 1'b0;
          else if (seg <= 8) ex = cur.data[seg-1];
          else ex = 1'b1;
          if (tx !== ex || busy !== 1'b1) dec_bad++;
        end else begin
          if (!dec_stray) begin
            chk("frame_bits", dec_bad, 0);
            chk("busy_end", int'(busy), 0);
            chk("cur_src", int'(cur_src), int'(cur.src));
            void'(sb.pop_front());
          end
          dec_active = 1'b0;
        end
      end else if (tx === 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
        dec_bad    = 0;
        if (sb.size() == 0) begin
          dec_stray = 1'b1;
          chk("stray_frame", 1, 0);
        end else begin
          dec_stray = 1'b0;
          cur = sb[0];
          chk("start_cycle", cyc, cur.cyc + 1);
          chk("busy_start", int'(busy), 1);
        end
      end
    end
  end

  task automatic step();
    logic [8:0] e;
    @(posedge clk);
    #1;
    if (cpu_acc_s && cpu_q.size() > 0) begin
      e = cpu_q.pop_front();
      if (e[8] && rnd_gaps) cpu_gap = $urandom_range(0, 3);
    end else if (cpu_gap > 0) cpu_gap--;
    if (dbg_acc_s && dbg_q.size() > 0) begin
      e = dbg_q.pop_front();
      if (e[8] && rnd_gaps) dbg_gap = $urandom_range(0, 3);
    end else if (dbg_gap > 0) dbg_gap--;
    cpu_valid = cpu_en && cpu_gap == 0 && cpu_q.size() > 0;
    dbg_valid = dbg_en && dbg_gap == 0 && dbg_q.size() > 0;
    if (cpu_q.size() > 0) begin
      e = cpu_q[0];
      cpu_data = e[7:0];
      cpu_last = e[8];
    end
    if (dbg_q.size() > 0) begin
      e = dbg_q[0];
      dbg_data = e[7:0];
      dbg_last = e[8];
    end
  endtask

  task automatic do_reset();
    cpu_q.delete();
    dbg_q.delete();
    cpu_gap = 0;
    dbg_gap = 0;
    rnd_gaps = 1'b0;
    tight = 1'b0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < maxc) begin
      step();
      n++;
      done = cpu_q.size() == 0 && dbg_q.size() == 0 && sb.size() == 0 && !dec_active && busy === 1'b0;
    end
    chk_ok(done, "drain_timeout", n, maxc);
  endtask

  task automatic wait_acc(input int maxc);
    int n;
    int base;
    n = 0;
    base = acc_total;
    while (acc_total == base && n < maxc) begin
      step();
      n++;
    end
    chk_ok(acc_total != base, "accept_timeout", n, maxc);
  endtask

  initial begin
    int t0;
    int len;
    #1 rst = 1'b0;
    cpu_valid = 1'b1;
    dbg_valid = 1'b1;
    #2;
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cur_src", int'(cur_src), 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_cpu_ready", int'(cpu_ready), 0);
    chk("reset_dbg_ready", int'(dbg_ready), 0);
    step();
    rst = 1'b1;

    // Single byte 0xA5.
    do_reset();
    cpu_en = 1'b1;
    dbg_en = 1'b0;
    cpu_q.push_back({1'b1, 8'hA5});
    wait_drain(200);
    chk("single_locked", int'(locked), 0);

    // Tie round-robin with continuous valids.
    do_reset();
    tight = 1'b1;
    cpu_en = 1'b1;
    dbg_en = 1'b1;
    cpu_q.push_back({1'b1, 8'h3A});
    cpu_q.push_back({1'b1, 8'h3B});
    dbg_q.push_back({1'b1, 8'hD1});
    dbg_q.push_back({1'b1, 8'hD2});
    wait_drain(400);

    // Packet lock held by dbg while cpu waits.
    do_reset();
    tight = 1'b1;
    cpu_en = 1'b0;
    dbg_en = 1'b1;
    dbg_q.push_back({1'b0, 8'h11});
    dbg_q.push_back({1'b0, 8'h22});
    dbg_q.push_back({1'b1, 8'h33});
    cpu_q.push_back({1'b1, 8'h77});
    wait_acc(10);
    cpu_en = 1'b1;
    wait_drain(400);
    chk("lock_released", int'(locked), 0);

    // Lock timeout after the cpu owner goes silent mid-packet.
    do_reset();
    cpu_en = 1'b1;
    dbg_en = 1'b1;
    cpu_q.push_back({1'b0, 8'h55});
    dbg_q.push_back({1'b1, 8'h66});
    wait_acc(10);
    t0 = acc_cyc;
    chk("timeout_first", int'(acc_who), 0);
    while (cyc < t0 + FRAME + LOCK_TIMEOUT) step();
    chk("lock_held", int'(locked), 1);
    m_locked = 1'b0;
    wait_acc(10);
    chk_ok(acc_who == 1'b1 && acc_cyc >= t0 + 49 && acc_cyc <= t0 + 50,
           "timeout_release", acc_cyc - t0, 50);
    wait_drain(200);

    // Reset in the middle of the third data bit.
    do_reset();
    cpu_en = 1'b1;
    dbg_en = 1'b0;
    cpu_q.push_back({1'b1, 8'hC3});
    wait_acc(10);
    t0 = acc_cyc;
    cpu_q.push_back({1'b1, 8'h3C});
    while (cyc < t0 + 14) step();
    rst = 1'b0;
    #1;
    chk("midrst_tx", int'(tx), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_cpu_ready", int'(cpu_ready), 0);
    step();
    step();
    rst = 1'b1;
    wait_drain(200);

    // Input data changes while the first byte is on the line.
    do_reset();
    cpu_en = 1'b1;
    dbg_en = 1'b0;
    cpu_q.push_back({1'b1, 8'hF0});
    cpu_q.push_back({1'b1, 8'h0F});
    wait_drain(200);

    // Randomized packets on both sources with gaps between packets.
    do_reset();
    rnd_gaps = 1'b1;
    cpu_en = 1'b1;
    dbg_en = 1'b1;
    for (int p = 0; p < 10; p++) begin
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) cpu_q.push_back({b == len - 1, 8'($urandom)});
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) dbg_q.push_back({b == len - 1, 8'($urandom)});
    end
    wait_drain(6000);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got %0d expected %0d", cyc, 0);
    $fatal(1);
  end

endmodule
